// File: rtl/parity_frame_serializer_if.sv
// Handshake and serial-stream bundle for parity_frame_serializer.
// master: the upstream word source that also watches the serial stream.
// slave : the serializer itself.
interface parity_frame_serializer_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              ser_out;
  logic              ser_frame;
  logic              ser_first;
  logic              ser_last;
  logic [15:0]       frames_sent;

  modport master (
    output in_valid, in_data,
    input  in_ready, ser_out, ser_frame, ser_first, ser_last, frames_sent
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, ser_out, ser_frame, ser_first, ser_last, frames_sent
  );
endinterface

// File: rtl/parity_frame_serializer.sv
// Parallel-to-serial framer: shifts a DATA_W-bit word out LSB-first, then
// appends one parity bit (even when PARITY_ODD=0, odd when 1).
// Optional build macro PARITY_ERR_INJECT_EN adds an err_inject input that
// inverts the parity bit of the word accepted alongside it.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | no frame in flight, ready for a word
// S_DATA   | shifting data bits, idx_q = bit currently on ser_out
// S_PARITY | parity bit on ser_out, may accept the next word
module parity_frame_serializer #(
  parameter int DATA_W     = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic clk,
  input  logic rstn,
`ifdef PARITY_ERR_INJECT_EN
  input  logic err_inject,
`endif
  parity_frame_serializer_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;

  localparam int                IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DATA_W - 1);
  localparam logic              ODD_BIT  = (PARITY_ODD != 0);

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              par_q, par_d;
  logic [15:0]       frames_q, frames_d;
  logic              ser_out_q, ser_out_d;
  logic              ser_frame_q, ser_frame_d;
  logic              ser_first_q, ser_first_d;
  logic              ser_last_q, ser_last_d;

  logic in_ready_c;
  logic accept;
  logic inj;

`ifdef PARITY_ERR_INJECT_EN
  assign inj = err_inject;
`else
  assign inj = 1'b0;
`endif

  // Ready depends on state alone so upstream never sees a valid->ready loop.
  assign in_ready_c = (state_q == S_IDLE) || (state_q == S_PARITY);
  assign accept     = bus.in_valid && in_ready_c;

  // Next-state, datapath and next-cycle output decode.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    shreg_d     = shreg_q;
    par_d       = par_q;
    frames_d    = frames_q;
    ser_out_d   = 1'b0;
    ser_frame_d = 1'b0;
    ser_first_d = 1'b0;
    ser_last_d  = 1'b0;

    case (state_q)
      S_IDLE: ;
      S_DATA: begin
        if (idx_q == IDX_LAST) begin
          state_d = S_PARITY;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          shreg_d = shreg_q >> 1;
        end
      end
      S_PARITY: begin
        frames_d = frames_q + 16'd1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A new word overrides the PARITY->IDLE exit, giving gap-free frames.
    if (accept) begin
      state_d = S_DATA;
      idx_d   = '0;
      shreg_d = bus.in_data;
      par_d   = (^bus.in_data) ^ ODD_BIT ^ inj;
    end

    // Outputs are registered, so decode them from the state being entered.
    case (state_d)
      S_DATA: begin
        ser_out_d   = shreg_d[0];
        ser_frame_d = 1'b1;
        ser_first_d = (idx_d == '0);
      end
      S_PARITY: begin
        ser_out_d   = par_d;
        ser_frame_d = 1'b1;
        ser_last_d  = 1'b1;
      end
      default: ;
    endcase
  end

  // State and output registers; synchronous reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      shreg_q     <= '0;
      par_q       <= 1'b0;
      frames_q    <= 16'd0;
      ser_out_q   <= 1'b0;
      ser_frame_q <= 1'b0;
      ser_first_q <= 1'b0;
      ser_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      par_q       <= par_d;
      frames_q    <= frames_d;
      ser_out_q   <= ser_out_d;
      ser_frame_q <= ser_frame_d;
      ser_first_q <= ser_first_d;
      ser_last_q  <= ser_last_d;
    end
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.ser_out     = ser_out_q;
  assign bus.ser_frame   = ser_frame_q;
  assign bus.ser_first   = ser_first_q;
  assign bus.ser_last    = ser_last_q;
  assign bus.frames_sent = frames_q;

endmodule
